// File: rtl/dlx_pkg.sv
// Shared DLX pipeline types and constants.
package dlx_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DLX_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc4;
    } fetch_pkt_t;
endpackage

// File: rtl/if_id_fetch_queue_if.sv
// IF->ID handshake bundle: fetch side in, decode side out, plus flush and occupancy.
interface if_id_fetch_queue_if #(
    parameter int XLEN  = dlx_pkg::XLEN,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] instruction_in;
    logic [XLEN-1:0] add_pc_4_in;
    logic            if_valid_in;
    logic            if_stall_out;
    logic            flush_in;
    logic [XLEN-1:0] instruction_out;
    logic [XLEN-1:0] pc_4_out;
    logic            id_valid_out;
    logic            id_ready_in;
    logic [CW-1:0]   count_out;

    modport master (
        output instruction_in, add_pc_4_in, if_valid_in, flush_in, id_ready_in,
        input  if_stall_out, instruction_out, pc_4_out, id_valid_out, count_out
    );

    modport slave (
        input  instruction_in, add_pc_4_in, if_valid_in, flush_in, id_ready_in,
        output if_stall_out, instruction_out, pc_4_out, id_valid_out, count_out
    );
endinterface

// File: rtl/if_id_fetch_queue_mem.sv
// Fetch packet storage: synchronous write, combinational (show-ahead) read.
module fetch_queue_mem
    import dlx_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fetch_pkt_t    wr_data,
    input  logic [AW-1:0] rd_addr,
    output fetch_pkt_t    rd_data
);
    fetch_pkt_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID decoupling queue: in-order fetch packets to decode, stalls IF when full,
// and drops everything on a redirect.
module if_id_fetch_queue
    import dlx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    if_id_fetch_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          not_empty;
    logic          push;
    logic          pop;
    fetch_pkt_t    wr_pkt;
    fetch_pkt_t    head_pkt;

    // Status comes only from the registered count, so a pop never frees a slot
    // for a push in the same cycle.
    assign full      = (count == CW'(DEPTH));
    assign not_empty = (count != '0);

    assign push = bus.if_valid_in & ~full & ~bus.flush_in;
    assign pop  = not_empty & bus.id_ready_in & ~bus.flush_in;

    assign wr_pkt.instr = bus.instruction_in;
    assign wr_pkt.pc4   = bus.add_pc_4_in;

    fetch_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_pkt),
        .rd_addr (rd_ptr),
        .rd_data (head_pkt)
    );

    always_ff @(posedge clk) begin
        if (reset || bus.flush_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign bus.if_stall_out    = full;
    assign bus.id_valid_out    = not_empty;
    assign bus.count_out       = count;
    assign bus.instruction_out = not_empty ? head_pkt.instr : DLX_NOP;
    assign bus.pc_4_out        = not_empty ? head_pkt.pc4 : '0;
endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Self-checking bench for if_id_fetch_queue against a queue-based reference model.
module tb_if_id_fetch_queue;
    import dlx_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    fetch_pkt_t    model_q[$];
    logic [31:0]   popped_pc[$];

    if_id_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

    if_id_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input logic vin, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic rdy, input logic flush);
        bus.if_valid_in    = vin;
        bus.instruction_in = instr;
        bus.add_pc_4_in    = pc4;
        bus.id_ready_in    = rdy;
        bus.flush_in       = flush;
    endtask

    // One clock: compare DUT with the model mid-cycle, then advance the model
    // using the textbook FIFO rules.
    task automatic cycle();
        bit         do_push, do_pop;
        fetch_pkt_t pkt;
        @(negedge clk);
        chk("count", 64'(bus.count_out), 64'(model_q.size()));
        chk("valid", 64'(bus.id_valid_out), 64'(model_q.size() != 0));
        chk("stall", 64'(bus.if_stall_out), 64'(model_q.size() == DEPTH));
        chk("instr", 64'(bus.instruction_out), model_q.size() != 0 ? 64'(model_q[0].instr) : 64'(DLX_NOP));
        chk("pc4",   64'(bus.pc_4_out), model_q.size() != 0 ? 64'(model_q[0].pc4) : 64'd0);
        if (!reset && !bus.flush_in && bus.id_valid_out && bus.id_ready_in)
            popped_pc.push_back(bus.pc_4_out);
        do_push = bus.if_valid_in && model_q.size() < DEPTH && !bus.flush_in;
        do_pop  = bus.id_ready_in && model_q.size() > 0 && !bus.flush_in;
        pkt.instr = bus.instruction_in;
        pkt.pc4   = bus.add_pc_4_in;
        @(posedge clk);
        if (reset || bus.flush_in) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(pkt);
        end
        #1;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        chk("rst_count", 64'(bus.count_out), 64'd0);
        chk("rst_instr", 64'(bus.instruction_out), 64'(DLX_NOP));

        // 1: three pushes, decode stalled
        drive(1'b1, 32'h2001_0005, 32'd4, 1'b0, 1'b0);  cycle();
        chk("t1_lat_pc4", 64'(bus.pc_4_out), 64'd4);
        drive(1'b1, 32'h2002_0006, 32'd8, 1'b0, 1'b0);  cycle();
        drive(1'b1, 32'h0022_1820, 32'd12, 1'b0, 1'b0); cycle();
        chk("t1_count", 64'(bus.count_out), 64'd3);
        chk("t1_head_i", 64'(bus.instruction_out), 64'h2001_0005);
        chk("t1_head_pc", 64'(bus.pc_4_out), 64'd4);
        chk("t1_stall", 64'(bus.if_stall_out), 64'd0);

        // 2: fill, overflow attempt, drain
        drive(1'b1, 32'h0000_0104, 32'd16, 1'b0, 1'b0); cycle();
        chk("t2_stall", 64'(bus.if_stall_out), 64'd1);
        drive(1'b1, 32'hdead_beef, 32'd20, 1'b0, 1'b0); cycle();
        chk("t2_ovf_count", 64'(bus.count_out), 64'd4);
        popped_pc.delete();
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (4) cycle();
        chk("t2_npop", 64'(popped_pc.size()), 64'd4);
        for (int i = 0; i < 4 && i < popped_pc.size(); i++)
            chk("t2_order", 64'(popped_pc[i]), 64'(4 * (i + 1)));
        chk("t2_empty", 64'(bus.id_valid_out), 64'd0);

        // 3: full queue sees push+pop together
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1000 + i, 32'(100 + 4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h2000, 32'd200, 1'b1, 1'b0); cycle();
        chk("t3_pop_only", 64'(bus.count_out), 64'd3);
        drive(1'b1, 32'h2000, 32'd200, 1'b0, 1'b0); cycle();
        chk("t3_refill", 64'(bus.count_out), 64'd4);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1); cycle();
        chk("t3_flush", 64'(bus.count_out), 64'd0);

        // 4: streaming through pointer wrap
        popped_pc.delete();
        drive(1'b1, 32'h3000_0001, 32'd4, 1'b0, 1'b0); cycle();
        for (int k = 2; k <= 10; k++) begin
            drive(1'b1, 32'(32'h3000_0000 + k), 32'(4 * k), 1'b1, 1'b0);
            cycle();
            chk("t4_count", 64'(bus.count_out), 64'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0); cycle();
        chk("t4_npop", 64'(popped_pc.size()), 64'd10);
        for (int i = 0; i < 10 && i < popped_pc.size(); i++)
            chk("t4_order", 64'(popped_pc[i]), 64'(4 * (i + 1)));

        // 5: flush with a fetch in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h4000 + i, 32'(300 + 4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h5555_5555, 32'd999, 1'b1, 1'b1); cycle();
        chk("t5_count", 64'(bus.count_out), 64'd0);
        chk("t5_valid", 64'(bus.id_valid_out), 64'd0);
        chk("t5_instr", 64'(bus.instruction_out), 64'd0);
        chk("t5_pc4", 64'(bus.pc_4_out), 64'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (2) cycle();
        chk("t5_no_ghost", 64'(bus.id_valid_out), 64'd0);

        // 6: reset mid-stream
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h6000 + i, 32'(400 + 4 * i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h6666_6666, 32'd500, 1'b1, 1'b0);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t6_count", 64'(bus.count_out), 64'd0);
        chk("t6_instr", 64'(bus.instruction_out), 64'd0);
        drive(1'b1, 32'h7777_0001, 32'h100, 1'b0, 1'b0); cycle();
        chk("t6_alone_cnt", 64'(bus.count_out), 64'd1);
        chk("t6_alone_pc", 64'(bus.pc_4_out), 64'h100);
        chk("t6_alone_i", 64'(bus.instruction_out), 64'h7777_0001);

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 600; n++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom(), $urandom(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
            reset = ($urandom_range(0, 59) == 0);
            cycle();
        end
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        repeat (5) cycle();
        chk("final_empty", 64'(bus.count_out), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
